// File: rtl/avst_sort_checker.sv
// avst_sort_checker: watches an Avalon-ST packet stream and reports, once per
// packet, whether the words arrived in non-decreasing unsigned order, plus the
// packet length, first word, last word and running packet/error counters.
// Framing errors (word without sop while idle, sop inside a packet) set a
// sticky flag.
module avst_sort_checker #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 1024,
  localparam int LW         = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              ready_en_i,
  output logic              done_o,
  output logic              sorted_o,
  output logic [LW-1:0]     len_o,
  output logic [DWIDTH-1:0] min_o,
  output logic [DWIDTH-1:0] max_o,
  output logic              err_frame_o,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [15:0]   CNT_MAX = 16'hFFFF;

  state_e              state_q, state_d;
  logic [LW-1:0]       cur_len_q, cur_len_d;
  logic                cur_sorted_q, cur_sorted_d;
  logic [DWIDTH-1:0]   prev_q, prev_d;
  logic [DWIDTH-1:0]   first_q, first_d;
  logic                done_q, done_d;
  logic                sorted_q, sorted_d;
  logic [LW-1:0]       len_q, len_d;
  logic [DWIDTH-1:0]   min_q, min_d;
  logic [DWIDTH-1:0]   max_q, max_d;
  logic                err_frame_q, err_frame_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic                ready_s;
  logic                xfer_s;
  logic                len_full_s;
  logic [LW-1:0]       step_len_s;
  logic                step_sorted_s;
  logic                end_pkt_s;
  logic [LW-1:0]       fin_len_s;
  logic                fin_sorted_s;
  logic [DWIDTH-1:0]   fin_first_s;

  // Ready is withheld during reset and for the single report cycle.
  assign ready_s     = ready_en_i & ~srst_i & (state_q != S_REPORT);
  assign xfer_s      = snk_valid_i & ready_s;
  assign snk_ready_o = ready_s;

  // Length/order bookkeeping for a continuation word of the current packet;
  // a word beyond the maximum length marks the packet unsorted.
  always_comb begin
    len_full_s    = (cur_len_q == MAX_LEN);
    step_sorted_s = cur_sorted_q & ~len_full_s & (snk_data_i >= prev_q);
    if (len_full_s) begin
      step_len_s = cur_len_q;
    end else begin
      step_len_s = cur_len_q + LEN_ONE;
    end
  end

  // Next-state, packet tracking and result/counter updates.
  always_comb begin
    state_d      = state_q;
    cur_len_d    = cur_len_q;
    cur_sorted_d = cur_sorted_q;
    prev_d       = prev_q;
    first_d      = first_q;
    done_d       = 1'b0;
    sorted_d     = sorted_q;
    len_d        = len_q;
    min_d        = min_q;
    max_d        = max_q;
    err_frame_d  = err_frame_q;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    end_pkt_s    = 1'b0;
    fin_len_s    = cur_len_q;
    fin_sorted_s = cur_sorted_q;
    fin_first_s  = first_q;

    case (state_q)
      S_IDLE, S_RECV: begin
        if (xfer_s) begin
          if (snk_startofpacket_i) begin
            // sop inside a packet abandons the old one without a report
            if (state_q == S_RECV) begin
              err_frame_d = 1'b1;
            end else begin
              err_frame_d = err_frame_q;
            end
            cur_len_d    = LEN_ONE;
            cur_sorted_d = 1'b1;
            prev_d       = snk_data_i;
            first_d      = snk_data_i;
            if (snk_endofpacket_i) begin
              end_pkt_s    = 1'b1;
              fin_len_s    = LEN_ONE;
              fin_sorted_s = 1'b1;
              fin_first_s  = snk_data_i;
            end else begin
              state_d = S_RECV;
            end
          end else if (state_q == S_RECV) begin
            cur_len_d    = step_len_s;
            cur_sorted_d = step_sorted_s;
            prev_d       = snk_data_i;
            if (snk_endofpacket_i) begin
              end_pkt_s    = 1'b1;
              fin_len_s    = step_len_s;
              fin_sorted_s = step_sorted_s;
              fin_first_s  = first_q;
            end else begin
              state_d = S_RECV;
            end
          end else begin
            // stray word while idle: dropped and flagged
            err_frame_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (end_pkt_s) begin
      state_d  = S_REPORT;
      done_d   = 1'b1;
      sorted_d = fin_sorted_s;
      len_d    = fin_len_s;
      min_d    = fin_first_s;
      max_d    = snk_data_i;
      if (pkt_cnt_q != CNT_MAX) begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end else begin
        pkt_cnt_d = pkt_cnt_q;
      end
      if (!fin_sorted_s && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= S_IDLE;
      cur_len_q    <= '0;
      cur_sorted_q <= 1'b0;
      prev_q       <= '0;
      first_q      <= '0;
      done_q       <= 1'b0;
      sorted_q     <= 1'b0;
      len_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      err_frame_q  <= 1'b0;
      pkt_cnt_q    <= 16'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      cur_len_q    <= cur_len_d;
      cur_sorted_q <= cur_sorted_d;
      prev_q       <= prev_d;
      first_q      <= first_d;
      done_q       <= done_d;
      sorted_q     <= sorted_d;
      len_q        <= len_d;
      min_q        <= min_d;
      max_q        <= max_d;
      err_frame_q  <= err_frame_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign done_o      = done_q;
  assign sorted_o    = sorted_q;
  assign len_o       = len_q;
  assign min_o       = min_q;
  assign max_o       = max_q;
  assign err_frame_o = err_frame_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_avst_sort_checker.sv
// Bench for avst_sort_checker: two instances (default length limit and a
// limit of 4) share one stimulus stream; a packet-level reference model keeps
// the words of the open packet in a queue and derives every expected output.
module tb_avst_sort_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, ren, valid, sop, eop;
  logic [7:0] data;

  logic        ready_a, done_a, sorted_a, err_a;
  logic [10:0] len_a;
  logic [7:0]  min_a, max_a;
  logic [15:0] pc_a, ec_a;

  logic        ready_b, done_b, sorted_b, err_b;
  logic [2:0]  len_b;
  logic [7:0]  min_b, max_b;
  logic [15:0] pc_b, ec_b;

  avst_sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(1024)) dut_a (
    .clk_i(clk), .srst_i(srst), .snk_data_i(data),
    .snk_startofpacket_i(sop), .snk_endofpacket_i(eop),
    .snk_valid_i(valid), .snk_ready_o(ready_a), .ready_en_i(ren),
    .done_o(done_a), .sorted_o(sorted_a), .len_o(len_a),
    .min_o(min_a), .max_o(max_a), .err_frame_o(err_a),
    .pkt_cnt_o(pc_a), .err_cnt_o(ec_a)
  );

  avst_sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(4)) dut_b (
    .clk_i(clk), .srst_i(srst), .snk_data_i(data),
    .snk_startofpacket_i(sop), .snk_endofpacket_i(eop),
    .snk_valid_i(valid), .snk_ready_o(ready_b), .ready_en_i(ren),
    .done_o(done_b), .sorted_o(sorted_b), .len_o(len_b),
    .min_o(min_b), .max_o(max_b), .err_frame_o(err_b),
    .pkt_cnt_o(pc_b), .err_cnt_o(ec_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         m_report, m_in_pkt;
  logic [7:0] m_q[$];
  int         m_done, m_err, m_min, m_max, m_pc;
  int         m_sorted[2], m_len[2], m_ec[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_report = 1'b0; m_in_pkt = 1'b0; m_q.delete();
    m_done = 0; m_err = 0; m_min = 0; m_max = 0; m_pc = 0;
    for (int k = 0; k < 2; k++) begin
      m_sorted[k] = 0; m_len[k] = 0; m_ec[k] = 0;
    end
  endfunction

  // packet result from the collected words, for each length limit
  function automatic void report_pkt();
    int lim, s;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 1024 : 4;
      s = (m_q.size() > lim) ? 0 : 1;
      for (int i = 1; i < m_q.size(); i++)
        if (m_q[i] < m_q[i-1]) s = 0;
      m_sorted[k] = s;
      m_len[k]    = (m_q.size() > lim) ? lim : m_q.size();
      if (s == 0 && m_ec[k] != 65535) m_ec[k]++;
    end
    m_min = m_q[0];
    m_max = m_q[m_q.size()-1];
    if (m_pc != 65535) m_pc++;
  endfunction

  task automatic check_outputs();
    chk("done_a",   done_a,   m_done);
    chk("sorted_a", sorted_a, m_sorted[0]);
    chk("len_a",    len_a,    m_len[0]);
    chk("min_a",    min_a,    m_min);
    chk("max_a",    max_a,    m_max);
    chk("err_a",    err_a,    m_err);
    chk("pkt_a",    pc_a,     m_pc);
    chk("ecnt_a",   ec_a,     m_ec[0]);
    chk("done_b",   done_b,   m_done);
    chk("sorted_b", sorted_b, m_sorted[1]);
    chk("len_b",    len_b,    m_len[1]);
    chk("min_b",    min_b,    m_min);
    chk("max_b",    max_b,    m_max);
    chk("err_b",    err_b,    m_err);
    chk("pkt_b",    pc_b,     m_pc);
    chk("ecnt_b",   ec_b,     m_ec[1]);
  endtask

  // one clock: drive at negedge, check ready, advance model, check after edge
  task automatic cycle(input bit v, input bit s, input bit e, input logic [7:0] d,
                       input bit re, input bit rs, output bit acc);
    bit xr;
    @(negedge clk);
    valid = v; sop = s; eop = e; data = d; ren = re; srst = rs;
    #1;
    xr = re && !rs && !m_report;
    chk("ready_a", ready_a, xr);
    chk("ready_b", ready_b, xr);
    acc = v && xr;
    if (rs) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_report) begin
        m_report = 1'b0;
      end else if (acc) begin
        if (s) begin
          if (m_in_pkt) m_err = 1;
          m_q.delete();
          m_q.push_back(d);
          m_in_pkt = 1'b1;
        end else if (m_in_pkt) begin
          m_q.push_back(d);
        end else begin
          m_err = 1;
        end
        if (m_in_pkt && e) begin
          report_pkt();
          m_in_pkt = 1'b0;
          m_report = 1'b1;
          m_done   = 1;
          m_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    int i, cyc;
    logic [7:0] run;
    srst = 1'b1; ren = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; data = 8'd0;
    model_reset();

    // reset state
    do_reset();
    do_reset();
    chk("rst_len", len_a, 0);
    chk("rst_pkt", pc_a, 0);
    idle(1);
    chk("rst_ready_after", ready_a, 1);

    // 1,2,2,5
    cycle(1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0, acc);
    chk("p1_done", done_a, 1);
    chk("p1_sorted", sorted_a, 1);
    chk("p1_len", len_a, 4);
    chk("p1_min", min_a, 1);
    chk("p1_max", max_a, 5);
    idle(1);
    chk("p1_pkt", pc_a, 1);

    // 3,7,4
    cycle(1'b1, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0, acc);
    chk("p2_sorted", sorted_a, 0);
    chk("p2_len", len_a, 3);
    idle(1);
    chk("p2_ecnt", ec_a, 1);

    // single word 9
    cycle(1'b1, 1'b1, 1'b1, 8'd9, 1'b1, 1'b0, acc);
    chk("p3_done", done_a, 1);
    chk("p3_ready_report", ready_a, 0);
    chk("p3_len", len_a, 1);
    chk("p3_min", min_a, 9);
    chk("p3_max", max_a, 9);
    idle(2);

    // framing errors: stray word, then sop restart mid-packet
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, acc);
    chk("p4_err_stray", err_a, 1);
    cycle(1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b1, 8'd6, 1'b1, 1'b0, acc);
    chk("p4_len", len_a, 2);
    chk("p4_min", min_a, 5);
    idle(1);
    chk("p4_pkt", pc_a, 1);
    chk("p4_err", err_a, 1);

    // 1..8 with ready_en toggling every cycle, valid held
    do_reset();
    i = 1; cyc = 0;
    while (i <= 8 && cyc < 40) begin
      cycle(1'b1, i == 1, i == 8, 8'(i), (cyc % 2) == 0, 1'b0, acc);
      if (acc) i++;
      cyc++;
    end
    chk("p5_all_accepted", i, 9);
    chk("p5_done", done_a, 1);
    chk("p5_len", len_a, 8);
    chk("p5_sorted", sorted_a, 1);
    idle(1);

    // ascending 6 words: over the limit of 4 on dut_b only
    for (int k = 1; k <= 6; k++)
      cycle(1'b1, k == 1, k == 6, 8'(k * 3), 1'b1, 1'b0, acc);
    chk("p6_sorted_b", sorted_b, 0);
    chk("p6_len_b", len_b, 4);
    chk("p6_sorted_a", sorted_a, 1);
    chk("p6_len_a", len_a, 6);
    idle(1);

    // reset mid-packet
    cycle(1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, acc);
    do_reset();
    chk("p7_len_b", len_b, 0);
    chk("p7_pkt_b", pc_b, 0);
    cycle(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, acc);
    idle(2);
    chk("p7_no_done", done_b, 0);
    chk("p7_err_b", err_b, 1);

    // random traffic
    do_reset();
    run = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      bit v, s, e, re, rs;
      logic [7:0] d;
      v  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 6) == 0);
      e  = ($urandom_range(0, 4) == 0);
      re = ($urandom_range(0, 4) != 0);
      rs = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 255));
      else d = run + 8'($urandom_range(0, 2));
      cycle(v, s, e, d, re, rs, acc);
      if (acc) run = d;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avst_sort_checker.md
AVST_SORT_CHECKER -- requirements
Module: avst_sort_checker

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits.
REQ-002 Parameter MAX_PKT_LEN, default 1024, maximum legal packet length in words; LW = $clog2(MAX_PKT_LEN)+1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  clock; all logic on rising edge.
REQ-005 srst_i  input  1  synchronous active-high reset.
REQ-006 snk_data_i  input  DWIDTH  packet word, unsigned.
REQ-007 snk_startofpacket_i  input  1  first word of packet.
REQ-008 snk_endofpacket_i  input  1  last word of packet.
REQ-009 snk_valid_i  input  1  word present.
REQ-010 snk_ready_o  output  1  checker accepts a word this cycle.
REQ-011 ready_en_i  input  1  bench-driven backpressure enable; 0 forces snk_ready_o low.
REQ-012 done_o  output  1  one-cycle pulse: packet result valid.
REQ-013 sorted_o  output  1  last packet was non-decreasing and well-formed.
REQ-014 len_o  output  LW  word count of last packet, saturating at MAX_PKT_LEN.
REQ-015 min_o / max_o  output  DWIDTH each  first / last word of last packet.
REQ-016 err_frame_o  output  1  sticky framing-error flag.
REQ-017 pkt_cnt_o / err_cnt_o  output  16 each  packets reported / packets reported unsorted, saturating at 16'hFFFF.

Function
REQ-018 Transfer occurs only when snk_valid_i && snk_ready_o in the same cycle; all other cycles SHALL leave data state unchanged.
REQ-019 snk_ready_o SHALL be ready_en_i && (state != REPORT); no combinational dependence on snk_valid_i.
REQ-020 FSM states IDLE, RECV, REPORT; reset state IDLE.
REQ-021 IDLE: transfer with sop && eop -> REPORT, len 1, sorted 1; transfer with sop only -> RECV, len 1, prev word = data.
REQ-022 IDLE: transfer without sop -> word discarded, err_frame_o set, stay IDLE.
REQ-023 RECV: transfer without sop -> len incremented (saturating), word compared with prev word; data < prev clears packet-sorted bit; prev word updated.
REQ-024 RECV: transfer with eop -> REPORT after the cycle; max_o takes the eop word.
REQ-025 RECV: transfer with sop -> err_frame_o set, current packet abandoned unreported, new packet restarted with this word (eop also set -> REPORT).
REQ-026 Packet length exceeding MAX_PKT_LEN SHALL clear packet-sorted bit; len_o holds MAX_PKT_LEN.
REQ-027 REPORT lasts exactly one cycle: done_o = 1, sorted_o/len_o/min_o/max_o updated on the same edge done_o rises, held until next REPORT; then -> IDLE.
REQ-028 pkt_cnt_o increments in REPORT; err_cnt_o increments in REPORT when sorted_o is 0; both saturate.
REQ-029 Comparison is unsigned; equal adjacent words count as sorted.
REQ-030 Latency: done_o asserted the cycle after the eop transfer.

Reset
REQ-031 srst_i SHALL return FSM to IDLE, abandon any in-progress packet, and zero done_o, sorted_o, len_o, min_o, max_o, err_frame_o, pkt_cnt_o, err_cnt_o.
REQ-032 During srst_i, snk_ready_o SHALL be 0; in the first cycle after reset, snk_ready_o = ready_en_i.
REQ-033 Reset asserted mid-packet SHALL produce no done_o pulse for that packet.

Verification
REQ-034 Packet 1,2,2,5 (sop on 1, eop on 5), ready_en_i=1 -> done_o one cycle after eop, sorted_o=1, len_o=4, min_o=1, max_o=5, pkt_cnt_o=1.
REQ-035 Packet 3,7,4 -> sorted_o=0, len_o=3, err_cnt_o=1.
REQ-036 Single word 9 with sop and eop -> done_o next cycle, sorted_o=1, len_o=1, min_o=max_o=9; snk_ready_o=0 during REPORT.
REQ-037 Word without sop in IDLE, then sop mid-packet -> err_frame_o=1, only the restarted packet reported, pkt_cnt_o=1.
REQ-038 Packet 1..8 with ready_en_i toggling every cycle and valid held -> only accepted words counted, len_o=8, sorted_o=1.
REQ-039 MAX_PKT_LEN=4, ascending packet of 6 words -> sorted_o=0, len_o=4; srst_i mid-packet afterwards -> all outputs 0, no done_o.
